cmd_rx: RTL and testbench
=========================

CMD_RX -- requirements
Module: cmd_rx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 5208, meaning clk cycles per UART bit (9600 baud at 50 MHz); legal range 16..65535.
REQ-002 The block SHALL have parameter TIMEOUT_BITS, default 20, meaning the maximum allowed gap, in bit-times, between the high-byte stop sample and the low-byte start edge.
REQ-003 The block SHALL have port clk, input, 1, meaning the system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port RX, input, 1, meaning the asynchronous UART serial line (8N1, LSB first, idle high), driven by CommMaster TX.
REQ-006 The block SHALL have port clr_cmd_rdy, input, 1, meaning a consumer acknowledge that clears cmd_rdy.
REQ-007 The block SHALL have port cmd, output, 16, meaning the last complete command word.
REQ-008 The block SHALL have port cmd_rdy, output, 1, meaning a new cmd is valid and unconsumed.
REQ-009 The block SHALL have port frm_err, output, 1, meaning a one-cycle pulse on a stop bit sampled low.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer, both flops preset to 1, before any use.
REQ-011 The byte receiver SHALL have states IDLE, START, DATA and STOP.
REQ-012 In IDLE, a synchronized RX of 0 SHALL cause the next state START with the baud counter loaded to BAUD_DIV/2 (integer division).
REQ-013 At START counter expiry, RX=1 SHALL be treated as a false start and return the receiver to IDLE with no output; RX=0 SHALL enter DATA with the counter loaded to BAUD_DIV.
REQ-014 In DATA, each expiry SHALL shift the sampled bit into the byte register at the MSB end (LSB-first arrival), reload BAUD_DIV, and enter STOP after 8 bits.
REQ-015 At STOP expiry, RX=1 SHALL deliver the byte (internal byte_vld, one cycle) and RX=0 SHALL pulse frm_err for one cycle and discard the byte; the receiver SHALL return to IDLE in both cases.
REQ-016 A new start edge SHALL be accepted on the cycle after the return to IDLE, so back-to-back frames are supported.
REQ-017 The assembler SHALL have states WAIT_HI and WAIT_LO.
REQ-018 In WAIT_HI, byte_vld SHALL latch the byte into a high-byte holding register, start the timeout counter and enter WAIT_LO.
REQ-019 In WAIT_LO, byte_vld SHALL load cmd = {held high byte, new byte} and set cmd_rdy on the following cycle, then enter WAIT_HI.
REQ-020 The timeout counter SHALL count clk cycles from entry to WAIT_LO and SHALL be frozen while the receiver is outside IDLE.
REQ-021 At a count of TIMEOUT_BITS*BAUD_DIV the assembler SHALL return to WAIT_HI, discard the held byte, and leave cmd and cmd_rdy unchanged.
REQ-022 A frm_err SHALL return the assembler to WAIT_HI and discard any held high byte.
REQ-023 cmd SHALL change only on a completed word and SHALL hold its value otherwise.
REQ-024 cmd_rdy SHALL be cleared on the cycle after clr_cmd_rdy=1.
REQ-025 cmd_rdy SHALL also be cleared when a new high byte is latched, indicating a new command is in progress.
REQ-026 If a cmd_rdy set and clr_cmd_rdy coincide, the set SHALL win.
REQ-027 clr_cmd_rdy while cmd_rdy=0 SHALL have no effect.
REQ-028 All counters SHALL be wide enough for their maximum count with no wrap-around; TIMEOUT_BITS*BAUD_DIV SHALL be sized at elaboration.

Reset
REQ-029 rst_n=0 SHALL immediately force the receiver to IDLE, the assembler to WAIT_HI, the synchronizer flops to 1, all counters to 0, cmd=16'h0000, cmd_rdy=0 and frm_err=0.
REQ-030 A reset asserted mid-frame SHALL discard partial data; after release the block SHALL wait for the next falling edge on RX and SHALL NOT decode an already-low RX as a start edge until RX has first been sampled high.

Verification (BAUD_DIV=16, TIMEOUT_BITS=20 in simulation)
REQ-031 The bench SHALL cover: CommMaster sends 16'h0001 -> cmd=16'h0001 and cmd_rdy=1 within 2 cycles after the low-byte stop sample; clr_cmd_rdy pulse -> cmd_rdy=0 next cycle and cmd stays 16'h0001.
REQ-032 The bench SHALL cover: back-to-back frames 8'hA5, 8'h3C with no idle gap -> cmd=16'hA53C.
REQ-033 The bench SHALL cover: an RX low glitch of 5 cycles -> false start, no byte delivered; a following 16'h1234 is received correctly.
REQ-034 The bench SHALL cover: a high byte 8'h55, then RX idle for 21 bit-times, then bytes 8'hBE, 8'hEF -> cmd=16'hBEEF with no 16'h55xx word produced.
REQ-035 The bench SHALL cover: a high byte whose stop bit is forced low -> frm_err pulses for exactly 1 cycle, and the next two bytes form a correct word.
REQ-036 The bench SHALL cover: rst_n asserted mid-low-byte -> cmd=0 and cmd_rdy=0 at once; the next full 16'hFFFF send is received correctly.

Source files
------------

// File: rtl/cmd_rx.sv
// UART 8N1 command receiver: assembles two consecutive bytes (high first) into a 16-bit command word.
// A gap longer than TIMEOUT_BITS bit-times or a framing error drops a half-received word.
module cmd_rx #(
    parameter int BAUD_DIV     = 5208,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);

    localparam int          TO_CYC    = TIMEOUT_BITS * BAUD_DIV;
    localparam int          TO_W      = $clog2(TO_CYC + 1);
    localparam logic [15:0] BAUD_FULL = 16'(BAUD_DIV);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

    rx_state_t   rx_state, rx_next;
    asm_state_t  asm_state, asm_next;

    logic          rx_ff1, rx_ff2, rx_s;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [15:0]   baud_cnt;
    logic          baud_tc;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [7:0]    hi_byte;
    logic          byte_vld;
    logic [TO_W-1:0] to_cnt;
    logic          to_expired;

    logic start_det, shift_en, byte_done, stop_bad;
    logic latch_hi, word_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1    <= 1'b1;
            rx_ff2    <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_ff1    <= RX;
            rx_ff2    <= rx_ff1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign rx_s    = rx_ff2;
    assign baud_tc = (baud_cnt == 16'd1);

    // Start detection is only armed once the line has been seen idle (after reset or a framing error).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            armed <= 1'b0;
        else if (stop_bad)
            armed <= 1'b0;
        else if (sync_fill[1] && rx_s)
            armed <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (armed && !rx_s)                rx_next = START;
            START: if (baud_tc)                       rx_next = rx_s ? IDLE : DATA;
            DATA:  if (baud_tc && bit_cnt == 3'd7)    rx_next = STOP;
            STOP:  if (baud_tc)                       rx_next = IDLE;
            default:                                  rx_next = IDLE;
        endcase
    end

    always_comb begin
        start_det = (rx_state == IDLE) && armed && !rx_s;
        shift_en  = (rx_state == DATA) && baud_tc;
        byte_done = (rx_state == STOP) && baud_tc && rx_s;
        stop_bad  = (rx_state == STOP) && baud_tc && !rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            byte_vld  <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            byte_vld <= byte_done;
            frm_err  <= stop_bad;
            if (start_det)
                baud_cnt <= BAUD_HALF;
            else if ((rx_state == START && baud_tc && !rx_s) || shift_en)
                baud_cnt <= BAUD_FULL;
            else if (baud_cnt != 16'd0)
                baud_cnt <= baud_cnt - 16'd1;
            if (rx_state == START)
                bit_cnt <= 3'd0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)
                shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) asm_state <= WAIT_HI;
        else        asm_state <= asm_next;
    end

    assign to_expired = (asm_state == WAIT_LO) && (to_cnt == '0);

    always_comb begin
        asm_next = asm_state;
        case (asm_state)
            WAIT_HI: if (byte_vld)                     asm_next = WAIT_LO;
            WAIT_LO: if (byte_vld || to_expired || frm_err) asm_next = WAIT_HI;
            default:                                   asm_next = WAIT_HI;
        endcase
    end

    always_comb begin
        latch_hi  = (asm_state == WAIT_HI) && byte_vld;
        word_done = (asm_state == WAIT_LO) && byte_vld;
    end

    // Gap timer runs only while the receiver idles, so a frame in flight never times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            hi_byte <= 8'h00;
            cmd     <= 16'h0000;
            cmd_rdy <= 1'b0;
        end else begin
            if (latch_hi)
                to_cnt <= TO_W'(TO_CYC);
            else if (rx_state == IDLE && to_cnt != '0)
                to_cnt <= to_cnt - TO_W'(1);
            if (latch_hi)
                hi_byte <= shift_reg;
            if (word_done)
                cmd <= {hi_byte, shift_reg};
            if (word_done)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || latch_hi)
                cmd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmd_rx.sv
// Bench for cmd_rx at BAUD_DIV=16, TIMEOUT_BITS=20: drives UART frames, scoreboards received words.
module tb_cmd_rx;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic        rdy_q = 1'b0;
    int          frm_cycles = 0;

    cmd_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .clr_cmd_rdy(clr_cmd_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // Capture every newly presented word and count frm_err high cycles.
    always @(negedge clk) begin
        if (cmd_rdy && !rdy_q) got_q.push_back(cmd);
        rdy_q = cmd_rdy;
        if (frm_err) frm_cycles++;
    end

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, output int lat);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_v;
        lat = -1;
        for (int i = 1; i <= BD; i++) begin
            @(negedge clk);
            if (lat < 0 && cmd_rdy) lat = i;
        end
        RX = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int lat;
        send_byte(w[15:8], 1'b1, lat);
        send_byte(w[7:0], 1'b1, lat);
    endtask

    task automatic wait_got(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && got_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (cmd !== 16'h0000) $display("FAIL reset_cmd got %h want 0000", cmd); else n_pass++;
        n_checks++; if (cmd_rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", cmd_rdy); else n_pass++;
        n_checks++; if (frm_err !== 1'b0) $display("FAIL reset_frm got %b want 0", frm_err); else n_pass++;
        rst_n = 1'b1;
        idle(3 * BD);
    endtask

    task automatic test_basic;
        int lat;
        logic [15:0] g, e;
        exp_q.push_back(16'h0001);
        send_byte(8'h00, 1'b1, lat);
        send_byte(8'h01, 1'b1, lat);
        n_checks++;
        if (lat < 11 || lat > 12) $display("FAIL basic_latency got %0d cycles want 11..12", lat); else n_pass++;
        wait_got(1, 50);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL basic_count got %0d words want 1", got_q.size());
        else begin
            n_pass++;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL basic_word got %h want %h", g, e); else n_pass++;
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        n_checks++; if (cmd_rdy !== 1'b0) $display("FAIL clr_rdy got %b want 0", cmd_rdy); else n_pass++;
        n_checks++; if (cmd !== 16'h0001) $display("FAIL clr_cmd got %h want 0001", cmd); else n_pass++;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_rdy !== 1'b0) $display("FAIL clr_idle_rdy got %b want 0", cmd_rdy); else n_pass++;
        n_checks++; if (cmd !== 16'h0001) $display("FAIL clr_idle_cmd got %h want 0001", cmd); else n_pass++;
        exp_q.delete(); got_q.delete();
    endtask

    // clr_cmd_rdy held high throughout: the word must still be flagged for a cycle.
    task automatic test_back_to_back;
        logic [15:0] g, e;
        clr_cmd_rdy = 1'b1;
        exp_q.push_back(16'hA53C);
        send_word(16'hA53C);
        clr_cmd_rdy = 1'b0;
        wait_got(1, 50);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL b2b_count got %0d words want 1", got_q.size());
        else begin
            n_pass++;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL b2b_word got %h want %h", g, e); else n_pass++;
        end
        n_checks++; if (cmd !== 16'hA53C) $display("FAIL b2b_cmd_hold got %h want a53c", cmd); else n_pass++;
        exp_q.delete(); got_q.delete();
        idle(2 * BD);
    endtask

    task automatic test_glitch;
        int f0;
        logic [15:0] g, e;
        f0 = frm_cycles;
        RX = 1'b0;
        repeat (5) @(negedge clk);
        idle(3 * BD);
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        wait_got(1, 50);
        n_checks++;
        if (frm_cycles != f0) $display("FAIL glitch_frm got %0d pulses want 0", frm_cycles - f0); else n_pass++;
        n_checks++;
        if (got_q.size() != 1) $display("FAIL glitch_count got %0d words want 1", got_q.size());
        else begin
            n_pass++;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL glitch_word got %h want %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
        idle(2 * BD);
    endtask

    task automatic test_timeout;
        int lat;
        logic [15:0] g, e;
        send_byte(8'h55, 1'b1, lat);
        idle(21 * BD);
        exp_q.push_back(16'hBEEF);
        send_word(16'hBEEF);
        wait_got(1, 50);
        idle(BD);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL timeout_count got %0d words want 1", got_q.size());
        else begin
            n_pass++;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL timeout_word got %h want %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
        idle(2 * BD);
    endtask

    // A held high byte (0x11) must be dropped by the framing error that follows it.
    task automatic test_frame_err;
        int lat, f0;
        logic [15:0] g, e;
        send_byte(8'h11, 1'b1, lat);
        f0 = frm_cycles;
        send_byte(8'h77, 1'b0, lat);
        idle(3 * BD);
        n_checks++;
        if (frm_cycles - f0 != 1) $display("FAIL frm_width got %0d cycles want 1", frm_cycles - f0); else n_pass++;
        exp_q.push_back(16'hC35A);
        send_word(16'hC35A);
        wait_got(1, 50);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL frm_count got %0d words want 1", got_q.size());
        else begin
            n_pass++;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL frm_word got %h want %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
        idle(2 * BD);
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [15:0] g, e;
        send_byte(8'h9A, 1'b1, lat);
        RX = 1'b0;
        repeat (5 * BD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (cmd !== 16'h0000) $display("FAIL rst_mid_cmd got %h want 0000", cmd); else n_pass++;
        n_checks++; if (cmd_rdy !== 1'b0) $display("FAIL rst_mid_rdy got %b want 0", cmd_rdy); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        idle(3 * BD);
        exp_q.push_back(16'hFFFF);
        send_word(16'hFFFF);
        wait_got(1, 50);
        idle(BD);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL rst_mid_count got %0d words want 1", got_q.size());
        else begin
            n_pass++;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL rst_mid_word got %h want %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_timeout();
        test_frame_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
